// File: rtl/seven_seg_scan_driver.sv
// Multi-digit time-multiplexed 7-segment driver: hex decode, per-digit DP,
// leading-zero suppression, blanking, anode guard time and frame-synchronous value update.
module seven_seg_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  LOAD,
  input  logic                  LZ_EN,
  input  logic                  BLANK,
  output logic [6:0]            SEG,
  output logic                  DP_OUT,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);

  localparam int unsigned VW    = 4 * DIGITS;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [VW-1:0]     shadow_val;
  logic [DIGITS-1:0] shadow_dp;
  logic              pending;
  logic [VW-1:0]     disp_val;
  logic [DIGITS-1:0] disp_dp;

  logic              last_slot_c;
  logic              last_digit_c;
  logic              wrap_c;
  logic [DIGITS-1:0] sel_c;
  logic [3:0]        nib_c;
  logic              dp_cur_c;
  logic              zero_from_c;
  logic              supp_c;
  logic [6:0]        seg_n_c;
  logic              dp_n_c;
  logic [DIGITS-1:0] an_n_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  // Scan position decode, digit select and active-high segment pattern for the current slot
  always_comb begin
    last_slot_c  = (cnt == CNT_W'(SCAN_DIV - 1));
    last_digit_c = (idx == IDX_W'(DIGITS - 1));
    wrap_c       = last_slot_c && last_digit_c;
    sel_c        = '0;
    nib_c        = 4'h0;
    dp_cur_c     = 1'b0;
    zero_from_c  = 1'b1;
    supp_c       = 1'b0;
    // zero_from_c accumulates "all nibbles from the top down to i are zero"
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_from_c = zero_from_c && (disp_val[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        sel_c[i] = 1'b1;
        nib_c    = disp_val[4*i +: 4];
        dp_cur_c = disp_dp[i];
        supp_c   = LZ_EN && (i != 0) && zero_from_c;
      end
    end
    seg_n_c = (BLANK || supp_c) ? 7'b0000000 : hex7(nib_c);
    dp_n_c  = BLANK ? 1'b0 : dp_cur_c;
    an_n_c  = ((cnt >= CNT_W'(GUARD)) && !BLANK) ? sel_c : '0;
  end

  // Prescaler, digit index, shadow/display registers and registered pin outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      SEG        <= SEG_POL;
      DP_OUT     <= SEG_ACTIVE_LOW;
      AN         <= AN_POL;
      FRAME      <= 1'b0;
    end else begin
      cnt <= last_slot_c ? '0 : cnt + CNT_W'(1);
      if (last_slot_c) begin
        idx <= last_digit_c ? '0 : idx + IDX_W'(1);
      end
      if (LOAD) begin
        shadow_val <= VALUE;
        shadow_dp  <= DP;
      end
      // A LOAD coinciding with the wrap commits the older shadow and stays pending
      if (wrap_c && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pending  <= LOAD;
      end else if (LOAD) begin
        pending <= 1'b1;
      end
      SEG    <= seg_n_c ^ SEG_POL;
      DP_OUT <= dp_n_c ^ SEG_ACTIVE_LOW;
      AN     <= an_n_c ^ AN_POL;
      FRAME  <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: three parameterisations driven in lockstep and
// checked every cycle against a time-based behavioural model of the display.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, lz_en, blank;
  logic [15:0] value;
  logic [3:0]  dp;

  logic [6:0] seg0, seg1, seg2;
  logic       dpo0, dpo1, dpo2;
  logic [3:0] an0, an2;
  logic [0:0] an1;
  logic       fr0, fr1, fr2;

  seven_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1),
                          .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) u_dut4 (
    .CLK(clk), .RST(rst), .VALUE(value), .DP(dp), .LOAD(load), .LZ_EN(lz_en),
    .BLANK(blank), .SEG(seg0), .DP_OUT(dpo0), .AN(an0), .FRAME(fr0));

  seven_seg_scan_driver #(.DIGITS(1), .SCAN_DIV(4), .GUARD(1),
                          .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) u_dut1 (
    .CLK(clk), .RST(rst), .VALUE(value[3:0]), .DP(dp[0:0]), .LOAD(load), .LZ_EN(lz_en),
    .BLANK(blank), .SEG(seg1), .DP_OUT(dpo1), .AN(an1), .FRAME(fr1));

  seven_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1),
                          .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_inv (
    .CLK(clk), .RST(rst), .VALUE(value), .DP(dp), .LOAD(load), .LZ_EN(lz_en),
    .BLANK(blank), .SEG(seg2), .DP_OUT(dpo2), .AN(an2), .FRAME(fr2));

  localparam logic [6:0] DEC [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int n_cmp = 0;
  int n_err = 0;

  // Model state per configuration: 0 = four digits, 1 = one digit
  int unsigned t_m    [2];
  logic [15:0] sh_v   [2];
  logic [3:0]  sh_dp  [2];
  logic        pend_m [2];
  logic [15:0] dv_m   [2];
  logic [3:0]  ddp_m  [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Predict the outputs produced by the coming edge, advance the model, then compare
  task automatic step();
    logic [6:0] es [2];
    logic       ed [2];
    logic [3:0] ea [2];
    logic       ef [2];
    for (int c = 0; c < 2; c++) begin
      int unsigned nd, per, pos, cnt, idx;
      logic [3:0]  off, dm, nib;
      logic [15:0] vm, hi;
      logic        supp;
      nd  = (c == 0) ? 4 : 1;
      off = (c == 0) ? 4'hF : 4'h1;
      vm  = (c == 0) ? 16'hFFFF : 16'h000F;
      dm  = (c == 0) ? 4'hF : 4'h1;
      if (rst) begin
        es[c] = 7'h00; ed[c] = 1'b0; ea[c] = off; ef[c] = 1'b0;
        t_m[c] = 0; sh_v[c] = '0; sh_dp[c] = '0; pend_m[c] = 1'b0;
        dv_m[c] = '0; ddp_m[c] = '0;
      end else begin
        per  = nd * 4;
        pos  = t_m[c] % per;
        cnt  = pos % 4;
        idx  = pos / 4;
        hi   = dv_m[c] >> (4 * idx);
        nib  = hi[3:0];
        supp = lz_en && (idx >= 1) && (hi == 16'h0);
        ea[c] = (cnt >= 1 && !blank) ? (off & ~(4'(1) << idx)) : off;
        es[c] = (blank || supp) ? 7'h00 : DEC[nib];
        ed[c] = blank ? 1'b0 : ddp_m[c][idx];
        ef[c] = (pos == per - 1);
        if (pos == per - 1 && pend_m[c]) begin
          dv_m[c]   = sh_v[c];
          ddp_m[c]  = sh_dp[c];
          pend_m[c] = load;
        end else if (load) begin
          pend_m[c] = 1'b1;
        end
        if (load) begin
          sh_v[c]  = value & vm;
          sh_dp[c] = dp & dm;
        end
        t_m[c]++;
      end
    end
    @(posedge clk);
    #1;
    check("seg4",   {1'b0, seg0},    {1'b0, es[0]});
    check("dp4",    {7'b0, dpo0},    {7'b0, ed[0]});
    check("an4",    {4'b0, an0},     {4'b0, ea[0]});
    check("frame4", {7'b0, fr0},     {7'b0, ef[0]});
    check("seg1",   {1'b0, seg1},    {1'b0, es[1]});
    check("dp1",    {7'b0, dpo1},    {7'b0, ed[1]});
    check("an1",    {7'b0, an1},     {7'b0, ea[1][0]});
    check("frame1", {7'b0, fr1},     {7'b0, ef[1]});
    check("seg_inv",{1'b0, seg2},    {1'b0, ~es[0]});
    check("dp_inv", {7'b0, dpo2},    {7'b0, ~ed[0]});
    check("an_inv", {4'b0, an2},     {4'b0, ea[0]});
    check("fr_inv", {7'b0, fr2},     {7'b0, ef[0]});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the next stepped cycle sits at frame position p of the four-digit scan
  task automatic wait_pos(input int unsigned p);
    for (int k = 0; k < 32 && (t_m[0] % 16) != p; k++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_en = 1'b0; blank = 1'b0; value = '0; dp = '0;
    run(3);
    rst = 1'b0;
    run(6);

    do_load(16'h12AF, 4'b0001);
    run(40);

    lz_en = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(36);
    do_load(16'h0000, 4'b0000);
    run(36);
    lz_en = 1'b0;

    wait_pos(1);
    do_load(16'h1111, 4'b0000);
    run(3);
    do_load(16'h2222, 4'b0010);
    wait_pos(15);
    do_load(16'h3333, 4'b0100);
    run(40);

    wait_pos(6);
    blank = 1'b1;
    run(5);
    blank = 1'b0;
    run(20);

    wait_pos(4);
    do_load(16'h9999, 4'b1111);
    run(3);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(40);

    for (int k = 0; k < 600; k++) begin
      value = 16'($urandom);
      dp    = 4'($urandom);
      load  = ($urandom % 6) == 0;
      blank = ($urandom % 25) == 0;
      rst   = ($urandom % 200) == 0;
      if (k % 50 == 0) lz_en = 1'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0; blank = 1'b0;
    run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
